// File: rtl/snake_pkg.sv
// Shared snake-game types: grid geometry, coordinate/bitmap typedefs and apple detector states.
package snake_pkg;

    localparam int GRID_DIM = 16;

    typedef logic [3:0] coord_t;
    typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        ARMED    = 2'd1,
        WAIT_NEW = 2'd2
    } apple_state_t;

endpackage

// File: rtl/row_priority_enc.sv
// Lowest-set-bit priority encoder; used for the column search and the fast-mode row search.
module row_priority_enc
    import snake_pkg::*;
#(
    parameter int W = GRID_DIM
) (
    input  logic [W-1:0]         i_vec,
    output logic [$clog2(W)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(W);

    // Walk downwards so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/apple_eat_detector.sv
// Decodes the one-hot apple bitmap, detects the snake head eating it and keeps a saturating score.
// Build option: define APPLE_SCAN_FAST_EN for a single-cycle full-grid decode instead of the row scan.
module apple_eat_detector
    import snake_pkg::*;
#(
    parameter int GRID        = GRID_DIM,
    parameter int SCORE_W     = 6,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            died,
    input  logic [GRID-1:0][GRID-1:0]       red_pixels,
    input  logic [$clog2(GRID)-1:0]         head_row,
    input  logic [$clog2(GRID)-1:0]         head_col,
    input  logic                            head_valid,
    output logic                            win,
    output logic [$clog2(GRID)-1:0]         apple_row,
    output logic [$clog2(GRID)-1:0]         apple_col,
    output logic                            apple_valid,
    output logic [SCORE_W-1:0]              score,
    output logic                            score_full
);

    localparam int CW = $clog2(GRID);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CW-1:0] next_row(input logic [CW-1:0] r);
        return (r == CW'(GRID - 1)) ? '0 : r + 1'b1;
    endfunction

    apple_state_t r_state, w_state_nxt;
    logic [CW-1:0]      r_row, w_row_nxt;
    logic               r_win, w_win_nxt;
    logic [CW-1:0]      r_apple_row, w_arow_nxt;
    logic [CW-1:0]      r_apple_col, w_acol_nxt;
    logic               r_apple_valid, w_avalid_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [3:0]         r_wait, w_wait_nxt;

    logic [CW-1:0] w_scan_row;
    logic [CW-1:0] w_scan_col;
    logic          w_col_any;
    logic          w_scan_hit;

`ifdef APPLE_SCAN_FAST_EN
    logic [GRID-1:0] w_row_any;
    logic            w_row_hit;

    for (genvar g = 0; g < GRID; g++) begin : g_row_any
        assign w_row_any[g] = |red_pixels[g];
    end

    row_priority_enc #(.W(GRID)) u_row_enc (
        .i_vec (w_row_any),
        .o_idx (w_scan_row),
        .o_any (w_row_hit)
    );

    assign w_scan_hit = w_row_hit & w_col_any;
`else
    assign w_scan_row = r_row;
    assign w_scan_hit = w_col_any;
`endif

    row_priority_enc #(.W(GRID)) u_col_enc (
        .i_vec (red_pixels[w_scan_row]),
        .o_idx (w_scan_col),
        .o_any (w_col_any)
    );

    logic w_apple_present;
    logic w_head_hit;

    assign w_apple_present = red_pixels[r_apple_row][r_apple_col];
    assign w_head_hit      = head_valid && (head_row == r_apple_row) && (head_col == r_apple_col);

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_win_nxt    = 1'b0;
        w_arow_nxt   = r_apple_row;
        w_acol_nxt   = r_apple_col;
        w_avalid_nxt = r_apple_valid;
        w_score_nxt  = r_score;
        w_wait_nxt   = r_wait;
        if (enable) begin
            case (r_state)
                SCAN: begin
                    if (w_scan_hit) begin
                        w_arow_nxt   = w_scan_row;
                        w_acol_nxt   = w_scan_col;
                        w_avalid_nxt = 1'b1;
                        w_row_nxt    = '0;
                        w_state_nxt  = ARMED;
                    end else begin
                        w_row_nxt = next_row(r_row);
                    end
                end
                // Death and relocation both outrank a same-cycle head match.
                ARMED: begin
                    if (died || !w_apple_present) begin
                        w_avalid_nxt = 1'b0;
                        w_row_nxt    = '0;
                        w_state_nxt  = SCAN;
                    end else if (w_head_hit) begin
                        w_win_nxt    = 1'b1;
                        w_score_nxt  = sat_inc(r_score);
                        w_avalid_nxt = 1'b0;
                        w_wait_nxt   = WAIT_INIT;
                        w_state_nxt  = WAIT_NEW;
                    end
                end
                WAIT_NEW: begin
                    if (died || r_wait <= 4'd1) begin
                        w_wait_nxt  = '0;
                        w_row_nxt   = '0;
                        w_state_nxt = SCAN;
                    end else begin
                        w_wait_nxt = r_wait - 1'b1;
                    end
                end
                default: begin
                    w_row_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SCAN;
            r_row         <= '0;
            r_win         <= 1'b0;
            r_apple_row   <= '0;
            r_apple_col   <= '0;
            r_apple_valid <= 1'b0;
            r_score       <= '0;
            r_wait        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_win         <= w_win_nxt;
            r_apple_row   <= w_arow_nxt;
            r_apple_col   <= w_acol_nxt;
            r_apple_valid <= w_avalid_nxt;
            r_score       <= w_score_nxt;
            r_wait        <= w_wait_nxt;
        end
    end

    assign win         = r_win;
    assign apple_row   = r_apple_row;
    assign apple_col   = r_apple_col;
    assign apple_valid = r_apple_valid;
    assign score       = r_score;
    assign score_full  = (r_score == SCORE_MAX);

endmodule

// File: tb/tb_apple_eat_detector.sv
// Directed bench for apple_eat_detector: scan latency, eating, death, relocation, saturation, freeze.
module tb_apple_eat_detector;

`ifdef APPLE_SCAN_FAST_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  died;
    logic [15:0][15:0]     red_pixels;
    logic [3:0]            head_row;
    logic [3:0]            head_col;
    logic                  head_valid;
    logic                  win;
    logic [3:0]            apple_row;
    logic [3:0]            apple_col;
    logic                  apple_valid;
    logic [5:0]            score;
    logic                  score_full;

    int checks = 0;
    int failures = 0;

    apple_eat_detector dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .died        (died),
        .red_pixels  (red_pixels),
        .head_row    (head_row),
        .head_col    (head_col),
        .head_valid  (head_valid),
        .win         (win),
        .apple_row   (apple_row),
        .apple_col   (apple_col),
        .apple_valid (apple_valid),
        .score       (score),
        .score_full  (score_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat(input int r);
        return (FAST != 0) ? 1 : r + 1;
    endfunction

    task automatic set_apple(input int r, input int c);
        red_pixels = '0;
        red_pixels[r][c] = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; died = 1'b0; head_valid = 1'b0;
        head_row = '0; head_col = '0;
        set_apple(5, 9);
        step(); step();
        checks++; if (win !== 1'b0) begin failures++; $display("FAIL reset_win got=%0b exp=0", win); end
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", apple_valid); end
        checks++; if (apple_row !== 4'd0 || apple_col !== 4'd0) begin failures++; $display("FAIL reset_pos got=%0d,%0d exp=0,0", apple_row, apple_col); end
        checks++; if (score !== 6'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (score_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", score_full); end
    endtask

    task automatic test_scan_latency();
        reset = 1'b0;
        for (int i = 1; i < lat(5); i++) step();
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL scan_early got=%0b exp=0", apple_valid); end
        step();
        checks++; if (apple_valid !== 1'b1) begin failures++; $display("FAIL scan_valid got=%0b exp=1", apple_valid); end
        checks++; if (apple_row !== 4'd5 || apple_col !== 4'd9) begin failures++; $display("FAIL scan_pos got=%0d,%0d exp=5,9", apple_row, apple_col); end
        checks++; if (win !== 1'b0 || score !== 6'd0) begin failures++; $display("FAIL scan_idle got win=%0b score=%0d exp win=0 score=0", win, score); end
    endtask

    task automatic test_eat();
        head_row = 4'd5; head_col = 4'd9; head_valid = 1'b1;
        step();
        head_valid = 1'b0;
        set_apple(2, 3);
        checks++; if (win !== 1'b1) begin failures++; $display("FAIL eat_win got=%0b exp=1", win); end
        checks++; if (score !== 6'd1) begin failures++; $display("FAIL eat_score got=%0d exp=1", score); end
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL eat_valid got=%0b exp=0", apple_valid); end
        step();
        checks++; if (win !== 1'b0) begin failures++; $display("FAIL eat_win_pulse got=%0b exp=0", win); end
        for (int i = 0; i < 4 + lat(2) - 2; i++) step();
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL eat_wait_valid got=%0b exp=0", apple_valid); end
        step();
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd2 || apple_col !== 4'd3) begin
            failures++; $display("FAIL eat_rescan got=%0b (%0d,%0d) exp=1 (2,3)", apple_valid, apple_row, apple_col);
        end
    endtask

    task automatic test_died();
        set_apple(0, 0);
        step();
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL died_move_valid got=%0b exp=0", apple_valid); end
        step();
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd0 || apple_col !== 4'd0) begin
            failures++; $display("FAIL died_find got=%0b (%0d,%0d) exp=1 (0,0)", apple_valid, apple_row, apple_col);
        end
        head_row = 4'd0; head_col = 4'd0; head_valid = 1'b0;
        step();
        checks++; if (win !== 1'b0 || apple_valid !== 1'b1) begin failures++; $display("FAIL died_nohv got win=%0b valid=%0b exp win=0 valid=1", win, apple_valid); end
        died = 1'b1;
        step();
        died = 1'b0;
        checks++; if (apple_valid !== 1'b0 || win !== 1'b0) begin failures++; $display("FAIL died_abort got valid=%0b win=%0b exp 0 0", apple_valid, win); end
        step();
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd0 || apple_col !== 4'd0) begin
            failures++; $display("FAIL died_refind got=%0b (%0d,%0d) exp=1 (0,0)", apple_valid, apple_row, apple_col);
        end
        checks++; if (score !== 6'd1) begin failures++; $display("FAIL died_score got=%0d exp=1", score); end
    endtask

    task automatic test_relocate();
        set_apple(7, 7);
        step();
        checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL reloc_drop got=%0b exp=0", apple_valid); end
        for (int i = 0; i < lat(7); i++) step();
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd7 || apple_col !== 4'd7) begin
            failures++; $display("FAIL reloc_find got=%0b (%0d,%0d) exp=1 (7,7)", apple_valid, apple_row, apple_col);
        end
        set_apple(1, 4);
        head_row = 4'd7; head_col = 4'd7; head_valid = 1'b1;
        step();
        head_valid = 1'b0;
        checks++; if (win !== 1'b0 || apple_valid !== 1'b0 || score !== 6'd1) begin
            failures++; $display("FAIL reloc_nowin got win=%0b valid=%0b score=%0d exp 0 0 1", win, apple_valid, score);
        end
        for (int i = 0; i < lat(1); i++) step();
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd1 || apple_col !== 4'd4) begin
            failures++; $display("FAIL reloc_new got=%0b (%0d,%0d) exp=1 (1,4)", apple_valid, apple_row, apple_col);
        end
    endtask

    task automatic test_saturate();
        int exp_score;
        head_row = 4'd1; head_col = 4'd4;
        for (int i = 0; i < 64; i++) begin
            head_valid = 1'b1;
            step();
            head_valid = 1'b0;
            exp_score = (2 + i > 63) ? 63 : 2 + i;
            checks++; if (win !== 1'b1) begin failures++; $display("FAIL sat_win[%0d] got=%0b exp=1", i, win); end
            checks++; if (score !== 6'(exp_score)) begin failures++; $display("FAIL sat_score[%0d] got=%0d exp=%0d", i, score, exp_score); end
            checks++; if (score_full !== (exp_score == 63)) begin failures++; $display("FAIL sat_full[%0d] got=%0b exp=%0b", i, score_full, exp_score == 63); end
            for (int k = 0; k < 4 + lat(1); k++) step();
        end
        checks++; if (apple_valid !== 1'b1 || score !== 6'd63) begin
            failures++; $display("FAIL sat_end got valid=%0b score=%0d exp 1 63", apple_valid, score);
        end
    endtask

    task automatic test_enable_freeze();
        int nstep;
        int rem;
        logic exp_valid;
        reset = 1'b1;
        red_pixels = '0;
        red_pixels[9][2] = 1'b1; red_pixels[9][7] = 1'b1; red_pixels[12][0] = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (score !== 6'd0 || score_full !== 1'b0) begin failures++; $display("FAIL frz_reset got score=%0d full=%0b exp 0 0", score, score_full); end
        nstep = (FAST != 0) ? 1 : 4;
        exp_valid = (FAST != 0);
        for (int i = 0; i < nstep; i++) step();
        enable = 1'b0;
        head_row = 4'd9; head_col = 4'd2;
        for (int i = 0; i < 10; i++) begin
            head_valid = i[0];
            step();
            checks++; if (win !== 1'b0 || apple_valid !== exp_valid || score !== 6'd0) begin
                failures++; $display("FAIL frz_hold[%0d] got win=%0b valid=%0b score=%0d exp 0 %0b 0", i, win, apple_valid, score, exp_valid);
            end
        end
        head_valid = 1'b0;
        enable = 1'b1;
        rem = lat(9) - nstep;
        for (int i = 0; i < rem; i++) begin
            checks++; if (apple_valid !== 1'b0) begin failures++; $display("FAIL frz_resume[%0d] got=%0b exp=0", i, apple_valid); end
            step();
        end
        checks++; if (apple_valid !== 1'b1 || apple_row !== 4'd9 || apple_col !== 4'd2) begin
            failures++; $display("FAIL frz_find got=%0b (%0d,%0d) exp=1 (9,2)", apple_valid, apple_row, apple_col);
        end
    endtask

    initial begin
        test_reset();
        test_scan_latency();
        test_eat();
        test_died();
        test_relocate();
        test_saturate();
        test_enable_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
